// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: holds the PC, fetches over a req/ack handshake and
// presents each word to the decoder, then applies the decoder's next-PC select.
module fetch_unit #(
  parameter int unsigned         PC_W     = 10,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     im_out,
  output logic            im_valid,
  input  logic            stall,
  input  logic            br_take,
  input  logic            jmp,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ISSUE
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc1;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] next_pc;

  assign imem_addr = pc;

  // Jump keeps the upper bits of pc+1 and replaces the low 10 bits with the target;
  // the element-wise overwrite avoids an empty slice when PC_W is exactly 10.
  always_comb begin
    pc1          = pc + PC_W'(1);
    br_off       = {{(PC_W-4){im_out[3]}}, im_out[3:0]};
    jmp_tgt      = pc1;
    jmp_tgt[9:0] = im_out[9:0];
    if (jmp)
      next_pc = jmp_tgt;
    else if (br_take)
      next_pc = pc1 + br_off;
    else
      next_pc = pc1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      im_out   <= '0;
      im_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            im_out   <= imem_rdata;
            im_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc       <= next_pc;
            im_valid <= 1'b0;
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          im_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder with variable ack delay and a
// per-instruction reference model of the PC sequence.
module tb_fetch_unit;

  localparam int unsigned PC_W = 10;
  localparam int unsigned M    = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack = 1'b0;
  logic [15:0]     imem_rdata = '0;
  logic [15:0]     im_out;
  logic            im_valid;
  logic            stall = 1'b0;
  logic            br_take = 1'b0;
  logic            jmp = 1'b0;
  logic [PC_W-1:0] pc;

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .im_out     (im_out),
    .im_valid   (im_valid),
    .stall      (stall),
    .br_take    (br_take),
    .jmp        (jmp),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [M];
  int unsigned exp_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC computed arithmetically from the instruction word.
  function automatic int unsigned model_next(input int unsigned p, input logic [15:0] w,
                                             input bit b, input bit j);
    int unsigned p1;
    int          off;
    p1 = (p + 1) % M;
    if (j)
      return (p1 / 1024) * 1024 + int'(w[9:0]);
    if (b) begin
      off = (w[3:0] >= 4'd8) ? int'(w[3:0]) - 16 : int'(w[3:0]);
      return int'((int'(p1) + off + int'(M)) % int'(M));
    end
    return p1;
  endfunction

  task automatic do_instr(input int dly, input int nstall, input bit b, input bit j);
    int          waitc;
    logic [15:0] word;
    logic [15:0] prev_out;
    waitc = 0;
    while (!imem_req && waitc < 20) begin
      tick();
      waitc++;
    end
    check("req_seen", imem_req, 1);
    check("addr", imem_addr, exp_pc);
    check("valid_lo_in_req", im_valid, 0);
    prev_out = im_out;
    for (int i = 0; i < dly; i++) begin
      tick();
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, exp_pc);
      check("no_valid_wo_ack", im_valid, 0);
      check("out_stable_req", im_out, prev_out);
    end
    word       = mem[exp_pc];
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    check("valid_after_ack", im_valid, 1);
    check("im_out_word", im_out, word);
    check("req_drop", imem_req, 0);
    for (int s = 0; s < nstall; s++) begin
      stall      = 1'b1;
      br_take    = 1'($urandom);
      jmp        = 1'($urandom);
      imem_ack   = 1'($urandom);
      imem_rdata = 16'($urandom);
      tick();
      check("stall_pc", pc, exp_pc);
      check("stall_out", im_out, word);
      check("stall_valid", im_valid, 1);
      check("stall_no_req", imem_req, 0);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    br_take  = b;
    jmp      = j;
    tick();
    br_take = 1'b0;
    jmp     = 1'b0;
    exp_pc  = model_next(exp_pc, word, b, j);
    check("retire_valid", im_valid, 0);
    check("next_pc", pc, exp_pc);
    check("next_req", imem_req, 1);
    check("out_held_retire", im_out, word);
  endtask

  initial begin
    for (int i = 0; i < int'(M); i++) mem[i] = 16'($urandom);
    exp_pc = 0;

    #2;
    check("rst_req", imem_req, 0);
    check("rst_valid", im_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_out", im_out, 0);
    tick();
    tick();
    rst = 1'b1;
    check("idle_no_req", imem_req, 0);
    tick();

    for (int k = 0; k < 4; k++) do_instr(0, 0, 0, 0);
    check("seq_pc4", pc, 4);
    do_instr(3, 0, 0, 0);
    check("delay_pc5", pc, 5);

    mem[5][3:0] = 4'hE;
    do_instr(0, 0, 1, 0);
    check("br_neg", pc, 4);
    do_instr(1, 0, 0, 0);
    mem[5][3:0] = 4'h3;
    do_instr(0, 0, 1, 0);
    check("br_pos", pc, 9);
    mem[9][9:0] = 10'h3F0;
    do_instr(0, 0, 1, 1);
    check("jmp_wins", pc, 10'h3F0);
    mem[10'h3F0][9:0] = 10'h3FF;
    do_instr(2, 1, 0, 1);
    do_instr(0, 0, 0, 0);
    check("wrap_seq", pc, 0);
    mem[0][9:0] = 10'h3FE;
    do_instr(0, 0, 0, 1);
    mem[10'h3FE][3:0] = 4'h7;
    do_instr(0, 0, 1, 0);
    check("wrap_br", pc, 6);
    do_instr(0, 4, 0, 0);
    check("after_stall", pc, 7);

    for (int k = 0; k < 150; k++)
      do_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 1'($urandom));

    // Asynchronous reset while a request is outstanding.
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_pc", pc, 0);
    check("arst_valid", im_valid, 0);
    check("arst_out", im_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_pc = 0;
    check("rel_no_req", imem_req, 0);
    tick();
    for (int k = 0; k < 10; k++)
      do_instr($urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
